nx_stream_serialiser: RTL and testbench
=======================================

// Module: nx_stream_serialiser
//
// PURPOSE
// Transmit side of the nx valid/ready stream. Accepts one wide message per handshake and emits it as
// BEATS = MSG_WIDTH/STREAM_WIDTH narrow beats, with outbound_last_o marking the final beat.
// Sits between message producers (node/control logic) and narrow stream fabric (skids, links).
// Supports back-to-back messages with no bubble between them.
//
// PARAMETERS
// STREAM_WIDTH  32   width of each outbound beat
// MSG_WIDTH     128  width of inbound message; integer multiple of STREAM_WIDTH, BEATS >= 2
// LSB_FIRST     1    1: beat 0 = msg[STREAM_WIDTH-1:0]; 0: beat 0 = msg[MSG_WIDTH-1 -: STREAM_WIDTH]
//
// PORTS
// clk_i             in   1             clock, all state on rising edge
// rst_ni            in   1             asynchronous, active-low reset
// msg_data_i        in   MSG_WIDTH     inbound message
// msg_valid_i       in   1             inbound message valid
// msg_ready_o       out  1             serialiser can accept a message this cycle
// outbound_data_o   out  STREAM_WIDTH  current beat
// outbound_last_o   out  1             current beat is final beat of message
// outbound_valid_o  out  1             beat valid
// outbound_ready_i  in   1             downstream accepts beat
// busy_o            out  1             message in flight (state == SEND)
//
// BEHAVIOUR
// - Reset (rst_ni low, async): state IDLE, beat_q = 0, msg_q = 0.
//   Outputs in reset: outbound_valid_o = 0, outbound_last_o = 0, outbound_data_o = 0, busy_o = 0, msg_ready_o = 1.
// - State: IDLE, SEND. beat_q is a $clog2(BEATS)-bit counter. msg_q holds the accepted message.
// - msg_ready_o = IDLE || (SEND && outbound_ready_i && beat_q == BEATS-1). This is a combinational path from
//   outbound_ready_i.
// - Message accept = msg_valid_i && msg_ready_o.
//   On accept: msg_q <= msg_data_i, beat_q <= 0, state <= SEND.
// - IDLE -> SEND on accept. First beat is valid the cycle after accept (latency 1); no combinational msg->beat path.
// - Beat handshake = outbound_valid_o && outbound_ready_i.
//   - Not last: beat_q increments.
//   - Last (beat_q == BEATS-1), with a simultaneous accept: reload msg_q, beat_q <= 0, stay SEND.
//     Zero bubble; next message's beat 0 is presented the following cycle.
//   - Last, no accept: state <= IDLE, beat_q <= 0.
// - Beat outputs:
//   - outbound_valid_o = busy_o = (state == SEND).
//   - outbound_last_o = SEND && beat_q == BEATS-1.
//   - outbound_data_o = slice beat_q of msg_q, ordered per LSB_FIRST.
//   - outbound_data_o is 0 in IDLE.
// - Stall: while outbound_valid_o && !outbound_ready_i, data, last and beat_q hold stable; msg_ready_o = 0.
//   Valid is never withdrawn once raised until the beat is accepted.
// - msg_data_i is sampled only on accept. Changes at other times have no effect.
// - beat_q never exceeds BEATS-1. No wrap beyond last; a non-power-of-2 BEATS must work (e.g. 96/32 = 3).
// - Reset mid-message: in-flight message discarded, no further beats. After release, first accept starts at beat 0.
// - Elaboration error if MSG_WIDTH % STREAM_WIDTH != 0 or BEATS < 2.
//
// TESTING
// 1. Defaults, single msg 0x44444444_33333333_22222222_11111111, ready=1 -> beats 0x11111111, 0x22222222,
//    0x33333333, 0x44444444 on cycles N+1..N+4, last only on 4th.
// 2. Same msg with ready low for 3 cycles at beat 1 -> 0x22222222 held valid and stable for 4 cycles,
//    msg_ready_o = 0 throughout, no beat lost or duplicated.
// 3. Two msgs offered back-to-back, ready=1 -> 8 consecutive valid beats, msg_ready_o = 1 exactly on the
//    accept-last cycle, last on beats 4 and 8.
// 4. LSB_FIRST=0, MSG_WIDTH=96 -> msg 0xCCCC_BBBB_AAAA (32b slices) emits 0x0000CCCC, 0x0000BBBB, 0x0000AAAA,
//    last on 3rd.
// 5. rst_ni low during beat 2 -> valid drops asynchronously. After release: IDLE, msg_ready_o = 1, next msg
//    starts at beat 0.
// 6. Random valid/ready (10k cycles) vs scoreboard -> beat sequence equals serialised accepted messages,
//    exactly one last per message.

Source files
------------

// File: rtl/nx_stream_serialiser_if.sv
// Handshake bundle for the nx stream serialiser: wide message in, narrow beats out.
// slave is the serialiser's view; master is the producer/consumer side.
interface nx_stream_serialiser_if #(
   parameter int unsigned STREAM_WIDTH = 32,
   parameter int unsigned MSG_WIDTH    = 128
);
   logic [MSG_WIDTH-1:0]    msg_data_i;
   logic                    msg_valid_i;
   logic                    msg_ready_o;
   logic [STREAM_WIDTH-1:0] outbound_data_o;
   logic                    outbound_last_o;
   logic                    outbound_valid_o;
   logic                    outbound_ready_i;
   logic                    busy_o;

   modport slave (
      input  msg_data_i,
      input  msg_valid_i,
      output msg_ready_o,
      output outbound_data_o,
      output outbound_last_o,
      output outbound_valid_o,
      input  outbound_ready_i,
      output busy_o
   );

   modport master (
      output msg_data_i,
      output msg_valid_i,
      input  msg_ready_o,
      input  outbound_data_o,
      input  outbound_last_o,
      input  outbound_valid_o,
      output outbound_ready_i,
      input  busy_o
   );
endinterface

// File: rtl/nx_stream_serialiser.sv
// Transmit side of the nx stream: takes one wide message per handshake and emits it
// as MSG_WIDTH/STREAM_WIDTH narrow beats, back-to-back messages without a bubble.
module nx_stream_serialiser #(
   parameter int unsigned STREAM_WIDTH = 32,
   parameter int unsigned MSG_WIDTH    = 128,
   parameter bit          LSB_FIRST    = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   nx_stream_serialiser_if.slave  bus
);

   localparam int unsigned BEATS  = MSG_WIDTH / STREAM_WIDTH;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   if ((MSG_WIDTH % STREAM_WIDTH) != 0 || BEATS < 2) begin : g_bad_params
      $error("nx_stream_serialiser: MSG_WIDTH must be a multiple of STREAM_WIDTH with at least 2 beats");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e                  state_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [MSG_WIDTH-1:0]    msg_q;

   logic                    sending;
   logic                    at_last;
   logic                    beat_hs;
   logic                    msg_ready;
   logic                    accept;
   logic [BEAT_W-1:0]       slice_idx;
   logic [STREAM_WIDTH-1:0] slices [BEATS];

   assign sending   = (state_q == ST_SEND);
   assign at_last   = (beat_q == LAST_BEAT);
   assign beat_hs   = sending && bus.outbound_ready_i;
   // Ready opens on the final beat handshake so the next message follows with no gap
   assign msg_ready = !sending || (beat_hs && at_last);
   assign accept    = bus.msg_valid_i && msg_ready;

   // State, beat counter and message holding register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         msg_q   <= '0;
      end else if (accept) begin
         state_q <= ST_SEND;
         beat_q  <= '0;
         msg_q   <= bus.msg_data_i;
      end else if (beat_hs) begin
         if (at_last) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
         end else begin
            beat_q  <= beat_q + BEAT_W'(1);
         end
      end
   end

   for (genvar b = 0; b < BEATS; b++) begin : g_slice
      assign slices[b] = msg_q[b*STREAM_WIDTH +: STREAM_WIDTH];
   end

   assign slice_idx = LSB_FIRST ? beat_q : (LAST_BEAT - beat_q);

   assign bus.msg_ready_o      = msg_ready;
   assign bus.outbound_valid_o = sending;
   assign bus.busy_o           = sending;
   assign bus.outbound_last_o  = sending && at_last;
   assign bus.outbound_data_o  = sending ? slices[slice_idx] : '0;

endmodule

// File: tb/tb_nx_stream_serialiser.sv
// Directed and randomised checks of nx_stream_serialiser (128/32 LSB-first and 96/32 MSB-first).
module tb_nx_stream_serialiser;

   localparam int unsigned SW  = 32;
   localparam int unsigned MW  = 128;
   localparam int unsigned MW3 = 96;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   nx_stream_serialiser_if #(.STREAM_WIDTH(SW), .MSG_WIDTH(MW))  if0 ();
   nx_stream_serialiser_if #(.STREAM_WIDTH(SW), .MSG_WIDTH(MW3)) if1 ();

   nx_stream_serialiser #(.STREAM_WIDTH(SW), .MSG_WIDTH(MW), .LSB_FIRST(1'b1)) dut0 (
      .clk_i (clk_i), .rst_ni (rst_ni), .bus (if0.slave));

   nx_stream_serialiser #(.STREAM_WIDTH(SW), .MSG_WIDTH(MW3), .LSB_FIRST(1'b0)) dut1 (
      .clk_i (clk_i), .rst_ni (rst_ni), .bus (if1.slave));

   typedef struct {
      logic [127:0]     msg;
      logic [3:0][31:0] beat;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } sb_beat_t;

   vec_t     vecs [4];
   sb_beat_t sb_q [$];
   int       n_msgs    = 0;
   int       dut_lasts = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One random-phase cycle: model predicts ready/valid/data/last, then the edge is taken
   task automatic rand_cycle(input logic v, input logic r, input logic [127:0] d);
      logic exp_mr;
      if0.msg_valid_i      = v;
      if0.msg_data_i       = d;
      if0.outbound_ready_i = r;
      #1;
      exp_mr = (sb_q.size() == 0) || (r && sb_q.size() == 1);
      chk("rand msg_ready", if0.msg_ready_o, exp_mr);
      chk("rand valid", if0.outbound_valid_o, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
         chk("rand data", if0.outbound_data_o, sb_q[0].d);
         chk("rand last", if0.outbound_last_o, sb_q[0].l);
         if (r) begin
            if (if0.outbound_last_o) dut_lasts++;
            void'(sb_q.pop_front());
         end
      end
      if (v && exp_mr) begin
         for (int b = 0; b < 4; b++) sb_q.push_back('{d: d[32*b +: 32], l: (b == 3)});
         n_msgs++;
      end
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0].msg  = 128'h44444444_33333333_22222222_11111111;
      vecs[0].beat = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      vecs[1].msg  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      vecs[1].beat = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
      vecs[2].msg  = 128'h0;
      vecs[2].beat = {32'h0, 32'h0, 32'h0, 32'h0};
      vecs[3].msg  = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
      vecs[3].beat = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};

      if0.msg_data_i = '0; if0.msg_valid_i = 1'b0; if0.outbound_ready_i = 1'b0;
      if1.msg_data_i = '0; if1.msg_valid_i = 1'b0; if1.outbound_ready_i = 1'b0;

      // Reset state
      #1;
      chk("reset valid", if0.outbound_valid_o, 1'b0);
      chk("reset last", if0.outbound_last_o, 1'b0);
      chk("reset data", if0.outbound_data_o, 32'h0);
      chk("reset busy", if0.busy_o, 1'b0);
      chk("reset msg_ready", if0.msg_ready_o, 1'b1);
      chk("reset dut1 valid", if1.outbound_valid_o, 1'b0);
      chk("reset dut1 msg_ready", if1.msg_ready_o, 1'b1);
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      tick();

      // Single messages, ready held high
      for (int v = 0; v < 4; v++) begin
         if0.outbound_ready_i = 1'b1;
         if0.msg_data_i       = vecs[v].msg;
         if0.msg_valid_i      = 1'b1;
         #1;
         chk("t1 idle msg_ready", if0.msg_ready_o, 1'b1);
         tick();
         if0.msg_valid_i = 1'b0;
         if0.msg_data_i  = ~vecs[v].msg;
         for (int b = 0; b < 4; b++) begin
            #1;
            chk("t1 valid", if0.outbound_valid_o, 1'b1);
            chk("t1 data", if0.outbound_data_o, vecs[v].beat[b]);
            chk("t1 last", if0.outbound_last_o, b == 3);
            tick();
         end
         chk("t1 idle after", if0.outbound_valid_o, 1'b0);
         chk("t1 busy after", if0.busy_o, 1'b0);
      end

      // Stall at beat 1 for three cycles
      if0.outbound_ready_i = 1'b1;
      if0.msg_data_i  = vecs[0].msg;
      if0.msg_valid_i = 1'b1;
      tick();
      if0.msg_valid_i = 1'b0;
      chk("t2 beat0", if0.outbound_data_o, 32'h11111111);
      tick();
      if0.outbound_ready_i = 1'b0;
      if0.msg_valid_i      = 1'b1;
      if0.msg_data_i       = vecs[1].msg;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("t2 stall data", if0.outbound_data_o, 32'h22222222);
         chk("t2 stall valid", if0.outbound_valid_o, 1'b1);
         chk("t2 stall last", if0.outbound_last_o, 1'b0);
         chk("t2 stall msg_ready", if0.msg_ready_o, 1'b0);
         tick();
      end
      if0.outbound_ready_i = 1'b1;
      if0.msg_valid_i      = 1'b0;
      #1;
      chk("t2 release data", if0.outbound_data_o, 32'h22222222);
      chk("t2 release msg_ready", if0.msg_ready_o, 1'b0);
      tick();
      chk("t2 beat2", if0.outbound_data_o, 32'h33333333);
      tick();
      chk("t2 beat3", if0.outbound_data_o, 32'h44444444);
      chk("t2 beat3 last", if0.outbound_last_o, 1'b1);
      tick();
      chk("t2 done", if0.outbound_valid_o, 1'b0);

      // Back-to-back messages
      if0.outbound_ready_i = 1'b1;
      if0.msg_data_i  = vecs[0].msg;
      if0.msg_valid_i = 1'b1;
      tick();
      if0.msg_data_i = vecs[1].msg;
      for (int b = 0; b < 8; b++) begin
         #1;
         chk("t3 valid", if0.outbound_valid_o, 1'b1);
         chk("t3 data", if0.outbound_data_o, (b < 4) ? vecs[0].beat[b] : vecs[1].beat[b-4]);
         chk("t3 last", if0.outbound_last_o, (b % 4) == 3);
         chk("t3 msg_ready", if0.msg_ready_o, (b % 4) == 3);
         tick();
         if (b == 3) if0.msg_valid_i = 1'b0;
      end
      chk("t3 done", if0.outbound_valid_o, 1'b0);

      // 96-bit message, MSB slice first
      if1.outbound_ready_i = 1'b1;
      if1.msg_data_i  = 96'h0000CCCC_0000BBBB_0000AAAA;
      if1.msg_valid_i = 1'b1;
      tick();
      if1.msg_valid_i = 1'b0;
      chk("t4 beat0", if1.outbound_data_o, 32'h0000CCCC);
      chk("t4 last0", if1.outbound_last_o, 1'b0);
      tick();
      chk("t4 beat1", if1.outbound_data_o, 32'h0000BBBB);
      chk("t4 last1", if1.outbound_last_o, 1'b0);
      tick();
      chk("t4 beat2", if1.outbound_data_o, 32'h0000AAAA);
      chk("t4 last2", if1.outbound_last_o, 1'b1);
      tick();
      chk("t4 done", if1.outbound_valid_o, 1'b0);

      // Asynchronous reset mid-message
      if0.outbound_ready_i = 1'b1;
      if0.msg_data_i  = vecs[1].msg;
      if0.msg_valid_i = 1'b1;
      tick();
      if0.msg_valid_i = 1'b0;
      tick();
      tick();
      chk("t5 beat2 before reset", if0.outbound_data_o, 32'hCAFEF00D);
      #2 rst_ni = 1'b0;
      #1;
      chk("t5 reset valid", if0.outbound_valid_o, 1'b0);
      chk("t5 reset busy", if0.busy_o, 1'b0);
      chk("t5 reset last", if0.outbound_last_o, 1'b0);
      chk("t5 reset data", if0.outbound_data_o, 32'h0);
      chk("t5 reset msg_ready", if0.msg_ready_o, 1'b1);
      @(posedge clk_i);
      #3 rst_ni = 1'b1;
      tick();
      chk("t5 no beats after", if0.outbound_valid_o, 1'b0);
      chk("t5 msg_ready after", if0.msg_ready_o, 1'b1);
      if0.msg_data_i  = vecs[0].msg;
      if0.msg_valid_i = 1'b1;
      tick();
      if0.msg_valid_i = 1'b0;
      chk("t5 restart beat0", if0.outbound_data_o, 32'h11111111);
      chk("t5 restart last", if0.outbound_last_o, 1'b0);
      repeat (4) tick();
      chk("t5 drained", if0.outbound_valid_o, 1'b0);

      // Random valid/ready against scoreboard
      for (int c = 0; c < 10000; c++) begin
         rand_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    {$urandom, $urandom, $urandom, $urandom});
      end
      for (int c = 0; c < 8; c++) rand_cycle(1'b0, 1'b1, '0);
      chk("rand drained", sb_q.size(), 0);
      chk("rand idle", if0.outbound_valid_o, 1'b0);
      chk("rand one last per msg", dut_lasts, n_msgs);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
